mcycle_ctrl: RTL

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

---
 rtl/mcycle_ctrl_pkg.sv | 92 +++++++++
 rtl/mcycle_ctrl_aludec.sv | 29 ++
 rtl/mcycle_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/mcycle_ctrl_pkg.sv
// Shared types, opcode/funct constants and the per-state control word for
// the multicycle controller.
package mcycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       pcwrite;
    logic       branch;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    aluop_t     aluop;
  } ctrl_t;

  // fetch_done qualifies the FETCH enables: true only on the last stall cycle.
  function automatic ctrl_t ctrl_of(input state_t s, input logic fetch_done);
    ctrl_t c;
    c       = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = fetch_done;
        c.pcwrite = fetch_done;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.branch  = 1'b1;
        c.pcsrc   = 2'b01;
      end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcycle_ctrl_aludec.sv
// Combinational ALU control decode from aluop and the R-type funct field.
module aludec
  import mcycle_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multicycle MIPS-style control FSM with a configurable fetch stall.
// Optional addi support is compiled in with MCYCLE_CTRL_ADDI_EN.
module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int FETCH_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic       pcen,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT);

  state_t     cur, nxt;
  logic [3:0] cnt, cnt_nxt;
  ctrl_t      ctrl;

  always_comb begin
    nxt     = S_FETCH;
    cnt_nxt = 4'd0;
    case (cur)
      S_FETCH: begin
        if (cnt == WAIT_LAST) nxt = S_DECODE;
        else begin
          nxt     = S_FETCH;
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_RTYPEEX;
          OP_BEQ:       nxt = S_BEQEX;
`ifdef MCYCLE_CTRL_ADDI_EN
          OP_ADDI:      nxt = S_ADDIEX;
`endif
          OP_J:         nxt = S_JEX;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      nxt = S_MEMRD;
        else if (op == OP_SW) nxt = S_MEMWR;
        else                  nxt = S_FETCH;
      end
      S_MEMRD:   nxt = S_MEMWB;
      S_RTYPEEX: nxt = S_RTYPEWB;
`ifdef MCYCLE_CTRL_ADDI_EN
      S_ADDIEX:  nxt = S_ADDIWB;
`endif
      default:   nxt = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= S_FETCH;
      cnt  <= 4'd0;
      ctrl <= ctrl_of(S_FETCH, WAIT_LAST == 4'd0);
    end else begin
      cur  <= nxt;
      cnt  <= cnt_nxt;
      ctrl <= ctrl_of(nxt, (nxt == S_FETCH) && (cnt_nxt == WAIT_LAST));
    end
  end

  assign iord     = ctrl.iord;
  assign irwrite  = ctrl.irwrite;
  assign memwrite = ctrl.memwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign pcen     = ctrl.pcwrite | (ctrl.branch & zero);
  assign state    = cur;

  aludec u_aludec (
    .aluop      (ctrl.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule
